// File: rtl/picorv32_mem_handshake_monitor.sv
// Passive handshake monitor for the picorv32 native memory bus.
// Follows each mem_valid/mem_ready transaction, keeps a short stall history,
// bounds the number of wait cycles and checks that a waiting request holds
// its fields steady. Errors are sticky and the first one is latched as a code.
// All outputs come straight from flops (or a decode of the state flop), and
// the monitor only observes the bus.
module picorv32_mem_handshake_monitor #(
  parameter int  HIST_LEN     = 5,
  parameter int  MAX_WAIT     = 15,
  parameter int  CHECK_STABLE = 1,
  parameter int  CNT_WIDTH    = 32,
  localparam int WAIT_W       = $clog2(MAX_WAIT + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [HIST_LEN-1:0]  stall_hist,
  output logic [WAIT_W-1:0]    wait_cnt,
  output logic                 txn_active,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 err_timeout,
  output logic                 err_unstable,
  output logic                 err_drop,
  output logic [1:0]           err_code
);

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
  localparam logic [1:0] CODE_UNSTABLE = 2'd2;
  localparam logic [1:0] CODE_DROP     = 2'd3;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Bus phase decode for the current cycle.
  logic stall;
  logic xfer;

  // Snapshot of the request taken when it first stalls.
  logic        cap_instr;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  logic              capture_en;
  logic              count_en;
  logic              fields_changed;
  logic              stable_viol;
  logic [WAIT_W-1:0] wait_d;
  logic              set_timeout;
  logic              set_unstable;
  logic              set_drop;
  logic [1:0]        new_code;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_WIDTH'(1);
    return r;
  endfunction

  assign stall      = mem_valid && !mem_ready;
  assign xfer       = mem_valid && mem_ready;
  assign txn_active = (state_q == S_WAIT);

  // Compare the live request against the snapshot; write data only matters for writes.
  always_comb begin
    fields_changed = (mem_instr != cap_instr)
                  || (mem_addr  != cap_addr)
                  || (mem_wstrb != cap_wstrb)
                  || ((cap_wstrb != 4'd0) && (mem_wdata != cap_wdata));
    stable_viol    = (CHECK_STABLE != 0) && fields_changed;
  end

  // Next-state logic: transaction tracking and error detection in priority order.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_cnt;
    capture_en   = 1'b0;
    count_en     = 1'b0;
    set_timeout  = 1'b0;
    set_unstable = 1'b0;
    set_drop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        count_en = xfer;
        if (stall) begin
          capture_en = 1'b1;
          wait_d     = WAIT_W'(1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completing beat is counted even if it also breaks a rule.
        count_en = xfer;
        if (!mem_valid) begin
          set_drop = 1'b1;
          state_d  = S_ERR;
        end else if (stable_viol) begin
          set_unstable = 1'b1;
          state_d      = S_ERR;
        end else if (mem_ready) begin
          wait_d  = '0;
          state_d = S_IDLE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          set_timeout = 1'b1;
          state_d     = S_ERR;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // First-error encoding; the same order as the WAIT checks.
  always_comb begin
    new_code = CODE_NONE;
    if (set_drop)          new_code = CODE_DROP;
    else if (set_unstable) new_code = CODE_UNSTABLE;
    else if (set_timeout)  new_code = CODE_TIMEOUT;
  end

  // State register and per-transaction wait counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
    end
  end

  // Request snapshot, loaded only when a new request starts stalling.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_instr <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else if (capture_en) begin
      cap_instr <= mem_instr;
      cap_addr  <= mem_addr;
      cap_wdata <= mem_wdata;
      cap_wstrb <= mem_wstrb;
    end
  end

  // Saturating count of completed transfers; frozen once an error is latched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xfer_count <= '0;
    end else if (count_en) begin
      xfer_count <= sat_inc(xfer_count);
    end
  end

  // Sticky error flags and the first-error code.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_timeout  <= 1'b0;
      err_unstable <= 1'b0;
      err_drop     <= 1'b0;
      err_code     <= CODE_NONE;
    end else begin
      if (set_timeout)  err_timeout  <= 1'b1;
      if (set_unstable) err_unstable <= 1'b1;
      if (set_drop)     err_drop     <= 1'b1;
      if (err_code == CODE_NONE) err_code <= new_code;
    end
  end

  // Stall history keeps shifting in every state, including after an error.
  generate
    if (HIST_LEN == 1) begin : g_hist_single
      // Single-bit history simply remembers the previous cycle's stall.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stall_hist <= '0;
        else         stall_hist <= stall;
      end
    end else begin : g_hist_shift
      // Shift the newest stall sample into bit 0.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stall_hist <= '0;
        else         stall_hist <= {stall_hist[HIST_LEN-2:0], stall};
      end
    end
  endgenerate

endmodule

// File: tb/tb_picorv32_mem_handshake_monitor.sv
// Bench for picorv32_mem_handshake_monitor. Four instances with different
// parameters watch the same bus; each is compared every cycle against a
// transaction-level model, with extra directed vectors and corner sequences.
module tb_picorv32_mem_handshake_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_chk  = 0;
  int n_fail = 0;

  // Default instance: HIST_LEN 5, MAX_WAIT 15, stability checked, 32-bit count.
  logic [4:0]  d_hist; logic [3:0] d_wc; logic d_act; logic [31:0] d_xc;
  logic        d_eto, d_eun, d_edr; logic [1:0] d_code;
  // Short timeout instance: MAX_WAIT 4.
  logic [4:0]  t_hist; logic [2:0] t_wc; logic t_act; logic [31:0] t_xc;
  logic        t_eto, t_eun, t_edr; logic [1:0] t_code;
  // Stability check disabled.
  logic [4:0]  n_hist; logic [3:0] n_wc; logic n_act; logic [31:0] n_xc;
  logic        n_eto, n_eun, n_edr; logic [1:0] n_code;
  // Minimal instance: HIST_LEN 1, MAX_WAIT 1, 2-bit saturating count.
  logic [0:0]  s_hist; logic [0:0] s_wc; logic s_act; logic [1:0] s_xc;
  logic        s_eto, s_eun, s_edr; logic [1:0] s_code;

  picorv32_mem_handshake_monitor u_dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .stall_hist(d_hist), .wait_cnt(d_wc), .txn_active(d_act), .xfer_count(d_xc),
    .err_timeout(d_eto), .err_unstable(d_eun), .err_drop(d_edr), .err_code(d_code));

  picorv32_mem_handshake_monitor #(.HIST_LEN(5), .MAX_WAIT(4), .CHECK_STABLE(1), .CNT_WIDTH(32)) u_to (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .stall_hist(t_hist), .wait_cnt(t_wc), .txn_active(t_act), .xfer_count(t_xc),
    .err_timeout(t_eto), .err_unstable(t_eun), .err_drop(t_edr), .err_code(t_code));

  picorv32_mem_handshake_monitor #(.HIST_LEN(5), .MAX_WAIT(15), .CHECK_STABLE(0), .CNT_WIDTH(32)) u_ns (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .stall_hist(n_hist), .wait_cnt(n_wc), .txn_active(n_act), .xfer_count(n_xc),
    .err_timeout(n_eto), .err_unstable(n_eun), .err_drop(n_edr), .err_code(n_code));

  picorv32_mem_handshake_monitor #(.HIST_LEN(1), .MAX_WAIT(1), .CHECK_STABLE(1), .CNT_WIDTH(2)) u_sm (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .stall_hist(s_hist), .wait_cnt(s_wc), .txn_active(s_act), .xfer_count(s_xc),
    .err_timeout(s_eto), .err_unstable(s_eun), .err_drop(s_edr), .err_code(s_code));

  // Transaction-level reference: an outstanding request, its snapshot, a wait
  // tally, a transfer tally and a stall history held as an integer.
  typedef struct {
    bit          pend;
    bit          dead;
    bit          instr;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    bit [3:0]    wstrb;
    int          waits;
    longint      xfers;
    longint      hist;
    bit          e_to;
    bit          e_un;
    bit          e_dr;
    int          code;
  } mdl_t;

  mdl_t m_dut, m_to, m_ns, m_sm;

  function automatic mdl_t mzero();
    mdl_t z;
    z.pend = 0; z.dead = 0; z.instr = 0; z.addr = 0; z.wdata = 0; z.wstrb = 0;
    z.waits = 0; z.xfers = 0; z.hist = 0; z.e_to = 0; z.e_un = 0; z.e_dr = 0; z.code = 0;
    return z;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int hl, input int mw, input bit chk_en,
                                 input int cw, input bit v, input bit ins, input bit r,
                                 input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
    mdl_t n;
    bit   stall;
    bit   moved;
    n = m;
    stall = v && !r;
    n.hist = ((m.hist << 1) | longint'(stall)) & ((longint'(1) << hl) - 1);
    if (m.dead) return n;
    if (v && r && (m.xfers < (longint'(1) << cw) - 1)) n.xfers = m.xfers + 1;
    if (!m.pend) begin
      if (stall) begin
        n.pend = 1; n.instr = ins; n.addr = a; n.wdata = d; n.wstrb = s; n.waits = 1;
      end
    end else begin
      moved = (ins != m.instr) || (a != m.addr) || (s != m.wstrb) ||
              ((m.wstrb != 0) && (d != m.wdata));
      if (!v)                   begin n.dead = 1; n.e_dr = 1; end
      else if (chk_en && moved) begin n.dead = 1; n.e_un = 1; end
      else if (r)               begin n.pend = 0; n.waits = 0; end
      else if (m.waits >= mw)   begin n.dead = 1; n.e_to = 1; end
      else                      n.waits = m.waits + 1;
    end
    if (n.code == 0) n.code = n.e_dr ? 3 : (n.e_un ? 2 : (n.e_to ? 1 : 0));
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_m(input string t, input mdl_t m, input logic [63:0] hist,
                       input logic [63:0] wc, input logic [63:0] act, input logic [63:0] xc,
                       input logic [63:0] eto, input logic [63:0] eun, input logic [63:0] edr,
                       input logic [63:0] code);
    chk({t, ".stall_hist"},   hist, 64'(m.hist));
    chk({t, ".wait_cnt"},     wc,   64'(m.waits));
    chk({t, ".txn_active"},   act,  64'(m.pend && !m.dead));
    chk({t, ".xfer_count"},   xc,   64'(m.xfers));
    chk({t, ".err_timeout"},  eto,  64'(m.e_to));
    chk({t, ".err_unstable"}, eun,  64'(m.e_un));
    chk({t, ".err_drop"},     edr,  64'(m.e_dr));
    chk({t, ".err_code"},     code, 64'(m.code));
  endtask

  // One clock: advance every model on the edge, then compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!resetn) begin
      m_dut = mzero(); m_to = mzero(); m_ns = mzero(); m_sm = mzero();
    end else begin
      m_dut = mstep(m_dut, 5, 15, 1'b1, 32, mem_valid, mem_instr, mem_ready, mem_addr, mem_wdata, mem_wstrb);
      m_to  = mstep(m_to,  5, 4,  1'b1, 32, mem_valid, mem_instr, mem_ready, mem_addr, mem_wdata, mem_wstrb);
      m_ns  = mstep(m_ns,  5, 15, 1'b0, 32, mem_valid, mem_instr, mem_ready, mem_addr, mem_wdata, mem_wstrb);
      m_sm  = mstep(m_sm,  1, 1,  1'b1, 2,  mem_valid, mem_instr, mem_ready, mem_addr, mem_wdata, mem_wstrb);
    end
    #1;
    cmp_m("dut", m_dut, 64'(d_hist), 64'(d_wc), 64'(d_act), 64'(d_xc), 64'(d_eto), 64'(d_eun), 64'(d_edr), 64'(d_code));
    cmp_m("to",  m_to,  64'(t_hist), 64'(t_wc), 64'(t_act), 64'(t_xc), 64'(t_eto), 64'(t_eun), 64'(t_edr), 64'(t_code));
    cmp_m("ns",  m_ns,  64'(n_hist), 64'(n_wc), 64'(n_act), 64'(n_xc), 64'(n_eto), 64'(n_eun), 64'(n_edr), 64'(n_code));
    cmp_m("sm",  m_sm,  64'(s_hist), 64'(s_wc), 64'(s_act), 64'(s_xc), 64'(s_eto), 64'(s_eun), 64'(s_edr), 64'(s_code));
  endtask

  task automatic set_bus(input logic v, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    mem_valid = v; mem_ready = r; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_bus(0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    resetn = 1'b1;
  endtask

  typedef struct {
    bit        pre_rst;
    bit        v;
    bit        r;
    bit [31:0] a;
    bit [3:0]  s;
    int        wc;
    bit        act;
    int        xc;
    int        hist;
    int        code;
  } vec_t;

  vec_t tbl [8];
  int   rdy_pct;

  initial begin
    // Zero-wait transfers, then a three-stall read at 0x100 completing on the 4th cycle.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h0,   4'h0, 0, 1'b0, 1, 5'b00000, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   4'h0, 0, 1'b0, 2, 5'b00000, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0,   4'h0, 0, 1'b0, 3, 5'b00000, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h100, 4'h0, 1, 1'b1, 0, 5'b00001, 0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 2, 1'b1, 0, 5'b00011, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 3, 1'b1, 0, 5'b00111, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h100, 4'h0, 0, 1'b0, 1, 5'b01110, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,   4'h0, 0, 1'b0, 1, 5'b11100, 0};

    m_dut = mzero(); m_to = mzero(); m_ns = mzero(); m_sm = mzero();
    resetn = 1'b0;
    set_bus(0, 0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("reset.xfer_count", 64'(d_xc), 64'd0);
    chk("reset.err_code",   64'(d_code), 64'd0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre_rst) do_reset();
      set_bus(tbl[i].v, tbl[i].r, tbl[i].a, 32'h0, tbl[i].s);
      tick();
      chk($sformatf("vec%0d.wait_cnt", i),   64'(d_wc),   64'(tbl[i].wc));
      chk($sformatf("vec%0d.txn_active", i), 64'(d_act),  64'(tbl[i].act));
      chk($sformatf("vec%0d.xfer_count", i), 64'(d_xc),   64'(tbl[i].xc));
      chk($sformatf("vec%0d.stall_hist", i), 64'(d_hist), 64'(tbl[i].hist));
      chk($sformatf("vec%0d.err_code", i),   64'(d_code), 64'(tbl[i].code));
    end

    // Timeout with MAX_WAIT 4; history keeps shifting and the count stays frozen.
    do_reset();
    set_bus(1, 0, 32'h300, 32'h0, 4'h0);
    repeat (4) tick();
    chk("timeout.wait_cnt_at_limit", 64'(t_wc), 64'd4);
    chk("timeout.not_yet", 64'(t_eto), 64'd0);
    tick();
    chk("timeout.err_timeout", 64'(t_eto), 64'd1);
    chk("timeout.err_code", 64'(t_code), 64'd1);
    chk("timeout.txn_active", 64'(t_act), 64'd0);
    chk("timeout.wait_cnt_held", 64'(t_wc), 64'd4);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("timeout.hist_shifts", 64'(t_hist), 64'(5'b11101));
    chk("timeout.xfer_frozen", 64'(t_xc), 64'd0);

    // Address moves on the 2nd wait cycle: error with checking, clean completion without.
    do_reset();
    set_bus(1, 0, 32'h200, 32'h0, 4'h0);
    tick();
    mem_addr = 32'h204;
    tick();
    chk("unstable.err_unstable", 64'(d_eun), 64'd1);
    chk("unstable.err_code", 64'(d_code), 64'd2);
    chk("unstable.ns_still_waiting", 64'(n_act), 64'd1);
    mem_ready = 1'b1;
    tick();
    chk("unstable.ns_xfer_count", 64'(n_xc), 64'd1);
    chk("unstable.ns_err_code", 64'(n_code), 64'd0);
    chk("unstable.dut_xfer_frozen", 64'(d_xc), 64'd0);

    // Valid drops at wait_cnt 2 while the address also moves: drop wins.
    do_reset();
    set_bus(1, 0, 32'h400, 32'h0, 4'h0);
    tick();
    tick();
    chk("drop.wait_cnt", 64'(d_wc), 64'd2);
    set_bus(0, 0, 32'h404, 32'h0, 4'h0);
    tick();
    chk("drop.err_drop", 64'(d_edr), 64'd1);
    chk("drop.err_code", 64'(d_code), 64'd3);
    chk("drop.err_unstable", 64'(d_eun), 64'd0);

    // Asynchronous reset mid-transaction with an error already latched elsewhere.
    do_reset();
    set_bus(1, 0, 32'h500, 32'h0, 4'h0);
    repeat (3) tick();
    chk("areset.pre_wait_cnt", 64'(d_wc), 64'd3);
    chk("areset.pre_sm_code", 64'(s_code), 64'd1);
    resetn = 1'b0;
    #2;
    chk("areset.wait_cnt", 64'(d_wc), 64'd0);
    chk("areset.txn_active", 64'(d_act), 64'd0);
    chk("areset.stall_hist", 64'(d_hist), 64'd0);
    chk("areset.sm_err_code", 64'(s_code), 64'd0);
    chk("areset.sm_err_timeout", 64'(s_eto), 64'd0);
    chk("areset.to_stall_hist", 64'(t_hist), 64'd0);
    set_bus(0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    resetn = 1'b1;
    set_bus(1, 1, 32'h600, 32'h0, 4'h0);
    tick();
    chk("areset.after_xfer_count", 64'(d_xc), 64'd1);

    // Saturation of the 2-bit counter.
    do_reset();
    set_bus(1, 1, 32'h700, 32'h0, 4'h0);
    repeat (5) tick();
    chk("sat.sm_xfer_count", 64'(s_xc), 64'd3);
    chk("sat.dut_xfer_count", 64'(d_xc), 64'd5);

    // Random episodes: mostly well-behaved stalls, occasional protocol breaks.
    for (int ep = 0; ep < 20; ep++) begin
      rdy_pct = (ep % 2 == 1) ? 50 : 15;
      do_reset();
      for (int c = 0; c < 150; c++) begin
        if (mem_valid && !mem_ready && ($urandom_range(99) < 96)) begin
          if ((mem_wstrb == 4'h0) && ($urandom_range(3) == 0)) mem_wdata = $urandom;
        end else begin
          mem_valid = ($urandom_range(3) != 0);
          mem_instr = 1'($urandom_range(1));
          mem_addr  = 32'($urandom_range(15)) << 2;
          mem_wdata = $urandom;
          mem_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
        end
        mem_ready = ($urandom_range(99) < rdy_pct);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_handshake_monitor.md
Name: picorv32_mem_handshake_monitor

Overview:
- Parametrised monitor for the picorv32 native memory interface, instantiated in formal and simulation testbenches beside the core.
- Tracks each mem_valid/mem_ready transaction and keeps a stall-history window of configurable length.
- Counts wait cycles against a configurable limit and checks that request fields stay stable while a request is waiting.
- Raises sticky error flags with a first-error code, and exposes signals that testbenches use to restrict or assert bus behaviour.

Parameters:
HIST_LEN, 5, number of cycles in the stall-history shift register (minimum 1)
MAX_WAIT, 15, maximum allowed consecutive stall cycles per transaction (minimum 1)
CHECK_STABLE, 1, 1 = check request fields while waiting; 0 = disable err_unstable
CNT_WIDTH, 32, width of the saturating transfer counter

Ports:
clk  input  1  clock
resetn  input  1  reset; asynchronous, active-low
mem_valid  input  1  core request valid
mem_instr  input  1  request is an instruction fetch
mem_ready  input  1  memory accepts/completes the request
mem_addr  input  32  request address
mem_wdata  input  32  write data
mem_wstrb  input  4  write byte strobes (0 = read)
stall_hist  output  HIST_LEN  bit0 = current-cycle stall of the previous cycle, bit k = stall k+1 cycles ago
wait_cnt  output  $clog2(MAX_WAIT+1)  consecutive stall cycles of the current transaction
txn_active  output  1  a request is outstanding (state WAIT)
xfer_count  output  CNT_WIDTH  completed transfers, saturating
err_timeout  output  1  sticky: wait exceeded MAX_WAIT
err_unstable  output  1  sticky: request field changed while waiting
err_drop  output  1  sticky: mem_valid fell before mem_ready
err_code  output  2  first error: 0 none, 1 timeout, 2 unstable, 3 drop

Behaviour:
- Reset (resetn low, asynchronous): all outputs and internal registers 0, state IDLE. Deassertion takes effect at the next clk edge.
- stall = mem_valid && !mem_ready.
- Every cycle: stall_hist <= {stall_hist[HIST_LEN-2:0], stall}. For HIST_LEN = 1, stall_hist <= stall. This update also runs in ERR.
- xfer = mem_valid && mem_ready. When xfer is seen in IDLE or WAIT, xfer_count increments and holds at all-ones.
- State IDLE:
  - xfer: stay in IDLE (zero-wait transfer).
  - stall: capture {mem_instr, mem_addr, mem_wdata, mem_wstrb}, set wait_cnt = 1, go to WAIT.
  - otherwise: stay in IDLE.
- State WAIT (txn_active = 1). Checks apply in this priority order:
  1. !mem_valid: err_drop, go to ERR.
  2. CHECK_STABLE and the current fields differ from the captured fields: err_unstable, go to ERR. mem_wdata is compared only when the captured mem_wstrb != 0.
  3. mem_ready: transfer completes, wait_cnt = 0, go to IDLE. A back-to-back new request needs a new cycle; the same-cycle xfer is counted once.
  4. wait_cnt == MAX_WAIT: err_timeout, go to ERR.
  5. otherwise: wait_cnt increments.
- State ERR (terminal until reset):
  - txn_active = 0, wait_cnt holds, xfer_count frozen.
  - Error flags are sticky. err_code is written only while it is 0, so the first error wins.
  - Simultaneous errors in one cycle resolve by the WAIT priority order.
- Outputs are registered and visible one cycle after the triggering edge.
- The monitor never drives the bus.

Test Plan:
1. Zero-wait transfers: mem_valid = mem_ready = 1 for 3 cycles -> xfer_count = 3, stall_hist = 0, txn_active stays 0, no errors.
2. Three-stall read, MAX_WAIT = 15: addr 0x100, wstrb 0, ready on the 4th cycle -> wait_cnt goes 1,2,3 then 0; stall_hist = 5'b00111 one cycle later; xfer_count = 1.
3. Timeout, MAX_WAIT = 4: valid held, ready never asserted -> err_timeout = 1 after wait_cnt reaches 4 plus one cycle, err_code = 1, xfer_count frozen, stall_hist keeps shifting.
4. Unstable address: mem_addr changes 0x200 -> 0x204 on the 2nd wait cycle -> err_unstable = 1, err_code = 2. With CHECK_STABLE = 0 the same stimulus completes normally.
5. Dropped request in wait: mem_valid falls while wait_cnt = 2, and on that same cycle the address also changes -> err_drop = 1, err_code = 3, err_unstable stays 0.
6. Reset mid-transaction: resetn pulses low while wait_cnt = 3 with err_code = 1 set -> all outputs 0 immediately without a clock edge; after release, a new zero-wait xfer gives xfer_count = 1.
